// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU-side memory path: default RAM geometry,
// requester port indices and arbitration mode encodings.
package cpu_mem_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 9;

    localparam int unsigned PORT_LSU = 0;
    localparam int unsigned PORT_IF  = 1;

    localparam int unsigned PRIO_ROUND_ROBIN = 0;
    localparam int unsigned PRIO_FIXED_LSU   = 1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester's view of the shared RAM: request/handshake and read response.
interface ram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
);

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way grant picker: round-robin via a pointer flop, or fixed priority for
// the LSU port. Grant is combinational and one-hot (or zero).
module rr_pick2
    import cpu_mem_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = PRIO_ROUND_ROBIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (!reset) begin
            if (req_i == 2'b11) begin
                if (FIXED_PRIO != PRIO_ROUND_ROBIN || ptr_q == 1'(PORT_LSU)) begin
                    gnt_o[PORT_LSU] = 1'b1;
                end else begin
                    gnt_o[PORT_IF] = 1'b1;
                end
                // Pointer moves to the loser of the conflict.
                if (FIXED_PRIO == PRIO_ROUND_ROBIN) begin
                    ptr_d = gnt_o[PORT_LSU];
                end
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'(PORT_LSU);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the LSU (port 0) and
// instruction fetch (port 1); one access per cycle, read data one cycle later.
module ram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned FIXED_PRIO = PRIO_ROUND_ROBIN
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_port_arbiter_if.slave     port0_if,
    ram_port_arbiter_if.slave     port1_if,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign req[PORT_LSU] = port0_if.req;
    assign req[PORT_IF]  = port1_if.req;

    rr_pick2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .clk  (clk),
        .reset(reset),
        .req_i(req),
        .gnt_o(gnt)
    );

    // With no grant the address is held so the RAM output stays stable.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_data = port0_if.wdata;
        if (gnt[PORT_LSU]) begin
            ram_we   = port0_if.we;
            ram_addr = port0_if.addr;
        end else if (gnt[PORT_IF]) begin
            ram_we   = port1_if.we;
            ram_addr = port1_if.addr;
            ram_data = port1_if.wdata;
        end
    end

    always_comb begin
        rvalid_d           = 2'b00;
        rvalid_d[PORT_LSU] = gnt[PORT_LSU] & ~port0_if.we;
        rvalid_d[PORT_IF]  = gnt[PORT_IF] & ~port1_if.we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            rvalid_q <= 2'b00;
        end else begin
            addr_q   <= ram_addr;
            rvalid_q <= rvalid_d;
        end
    end

    assign port0_if.gnt    = gnt[PORT_LSU];
    assign port1_if.gnt    = gnt[PORT_IF];
    // Masking by reset drops a response whose grant preceded reset rising.
    assign port0_if.rvalid = rvalid_q[PORT_LSU] & ~reset;
    assign port1_if.rvalid = rvalid_q[PORT_IF] & ~reset;
    assign port0_if.rdata  = ram_q;
    assign port1_if.rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: round-robin arbiter with a 32x512 RAM model, plus a
// fixed-priority instance driven alongside for the priority checks.
module tb_ram_port_arbiter;

    logic clk;
    logic reset;

    ram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) p0_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) p1_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) f0_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) f1_if ();

    logic [8:0]  ram_addr, f_ram_addr;
    logic [31:0] ram_data, f_ram_data;
    logic        ram_we, f_ram_we;
    logic [31:0] ram_q;

    logic [31:0] mem [512];
    logic [8:0]  mem_addr_q;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ram_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .FIXED_PRIO(0)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .port0_if(p0_if),
        .port1_if(p1_if),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_we  (ram_we),
        .ram_q   (ram_q)
    );

    ram_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .FIXED_PRIO(1)
    ) u_dut_fp (
        .clk     (clk),
        .reset   (reset),
        .port0_if(f0_if),
        .port1_if(f1_if),
        .ram_addr(f_ram_addr),
        .ram_data(f_ram_data),
        .ram_we  (f_ram_we),
        .ram_q   (32'h0)
    );

    // RAM model: registered read address, so a read after a write sees new data.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        mem_addr_q <= ram_addr;
    end
    assign ram_q = mem[mem_addr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gnts();
        return {30'd0, p1_if.gnt, p0_if.gnt};
    endfunction

    function automatic logic [31:0] rvals();
        return {30'd0, p1_if.rvalid, p0_if.rvalid};
    endfunction

    function automatic logic [31:0] fgnts();
        return {30'd0, f1_if.gnt, f0_if.gnt};
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222;

        reset = 1'b1;
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 9'h001; p0_if.wdata = 32'h0;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 9'h002; p1_if.wdata = 32'h0;
        f0_if.req = 1'b1; f0_if.we = 1'b0; f0_if.addr = 9'h001; f0_if.wdata = 32'h0;
        f1_if.req = 1'b1; f1_if.we = 1'b0; f1_if.addr = 9'h002; f1_if.wdata = 32'h0;

        // Reset held with both ports requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_gnt", gnts(), 32'd0);
            check_eq("rst_rvalid", rvals(), 32'd0);
            check_eq("rst_we", {31'd0, ram_we}, 32'd0);
            check_eq("rst_fp_gnt", fgnts(), 32'd0);
            next_cycle();
        end
        reset = 1'b0;

        // Round-robin reads: first conflict after reset goes to port 0.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("rr_gnt", gnts(), (k % 2 == 0) ? 32'd1 : 32'd2);
            check_eq("fp_gnt", fgnts(), 32'd1);
            if (k > 0) begin
                check_eq("rr_rvalid", rvals(), (k % 2 == 1) ? 32'd1 : 32'd2);
                check_eq("rr_rdata", p0_if.rdata, (k % 2 == 1) ? 32'h1111_1111 : 32'h2222_2222);
            end
            next_cycle();
        end
        p0_if.req = 1'b0; p1_if.req = 1'b0;
        f0_if.req = 1'b0;
        @(negedge clk);
        check_eq("rr_rvalid_last", rvals(), 32'd2);
        check_eq("rr_rdata_last", p1_if.rdata, 32'h2222_2222);
        check_eq("fp_drop_req0", fgnts(), 32'd2);
        next_cycle();
        f1_if.req = 1'b0;

        // Single port: write then read the same address back-to-back.
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 9'h010; p0_if.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("sp_wr_gnt", gnts(), 32'd1);
        check_eq("sp_wr_we", {31'd0, ram_we}, 32'd1);
        next_cycle();
        p0_if.we = 1'b0;
        @(negedge clk);
        check_eq("sp_rd_gnt", gnts(), 32'd1);
        check_eq("sp_wr_no_rvalid", rvals(), 32'd0);
        next_cycle();
        p0_if.req = 1'b0;
        @(negedge clk);
        check_eq("sp_rvalid", rvals(), 32'd1);
        check_eq("sp_rdata", p0_if.rdata, 32'hDEAD_BEEF);
        check_eq("idle_we", {31'd0, ram_we}, 32'd0);
        next_cycle();

        // Same-address conflict, pointer at port 0: write wins, read sees new data.
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 9'h1FF; p0_if.wdata = 32'h1234_5678;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 9'h1FF;
        @(negedge clk);
        check_eq("cf0_gnt", gnts(), 32'd1);
        next_cycle();
        p0_if.req = 1'b0;
        @(negedge clk);
        check_eq("cf0_gnt1", gnts(), 32'd2);
        next_cycle();
        p1_if.req = 1'b0;
        @(negedge clk);
        check_eq("cf0_rvalid", rvals(), 32'd2);
        check_eq("cf0_rdata", p1_if.rdata, 32'h1234_5678);
        next_cycle();

        // Pointer now at port 1: the read wins and returns the old value.
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 9'h1FE; p0_if.wdata = 32'hAAAA_5555;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 9'h1FE;
        @(negedge clk);
        check_eq("cf1_gnt", gnts(), 32'd2);
        next_cycle();
        p1_if.req = 1'b0;
        @(negedge clk);
        check_eq("cf1_gnt0", gnts(), 32'd1);
        check_eq("cf1_rvalid", rvals(), 32'd2);
        check_eq("cf1_rdata", p1_if.rdata, 32'h0);
        next_cycle();
        p0_if.we = 1'b0;
        @(negedge clk);
        check_eq("cf1_rd_gnt", gnts(), 32'd1);
        next_cycle();
        p0_if.req = 1'b0;
        @(negedge clk);
        check_eq("cf1_rd_rdata", p0_if.rdata, 32'hAAAA_5555);
        next_cycle();

        // Reset mid-read: conflict moves pointer to port 1, then reset drops the response.
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 9'h010;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 9'h1FF;
        @(negedge clk);
        check_eq("mr_gnt", gnts(), 32'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check_eq("mr_rvalid", rvals(), 32'd0);
        check_eq("mr_gnt_rst", gnts(), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("mr_ptr_reset", gnts(), 32'd1);
        check_eq("mr_rvalid_after", rvals(), 32'd0);
        next_cycle();
        p0_if.req = 1'b0; p1_if.req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
